// File: rtl/wager_controller.sv
// Bankroll and round scheduler: takes bets, starts a round, settles the payout.
// Optional 5% dealer-win commission when WAGER_COMMISSION_EN is defined.
module wager_controller #(
    parameter int START_BALANCE = 100,
    parameter int BAL_W         = 8,
    parameter int MAX_BET       = 50,
    parameter int TIE_MULT      = 8
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic [1:0]       bet_in,
    input  logic [BAL_W-1:0] amount_in,
    input  logic             place_bet,
    input  logic             game_done,
    input  logic [1:0]       result,
    output logic             game_start,
    output logic             betting,
    output logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] wager,
    output logic [1:0]       bet_side,
    output logic [BAL_W-1:0] last_payout,
    output logic             payout_valid,
    output logic             reject,
    output logic             bankrupt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_BROKE  = 2'd3;

    localparam int PW  = BAL_W + 5;
    localparam int TOP = (1 << BAL_W) - 1;

    logic [1:0]       r_state;
    logic [BAL_W-1:0] r_balance;
    logic [BAL_W-1:0] r_wager;
    logic [1:0]       r_side;
    logic [1:0]       r_result;
    logic [BAL_W-1:0] r_last_payout;
    logic             r_game_start;
    logic             r_payout_valid;
    logic             r_reject;
    logic             r_betting;
    logic             r_bankrupt;

    logic             w_legal;
    logic [PW-1:0]    w_wag;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_dealer_win;
    logic [PW-1:0]    w_tie_win;
    logic [PW-1:0]    w_pay;
    logic [PW-1:0]    w_sum;
    logic [BAL_W-1:0] w_new_bal;
    logic [BAL_W-1:0] w_pay_sat;

    assign w_legal = (bet_in != 2'b00)
                  && (amount_in != '0)
                  && (amount_in <= BAL_W'(MAX_BET))
                  && (amount_in <= r_balance);

    assign w_wag     = PW'(r_wager);
    assign w_win     = w_wag + w_wag;
    assign w_tie_win = w_wag * PW'(TIE_MULT + 1);

`ifdef WAGER_COMMISSION_EN
    assign w_dealer_win = w_win - (w_wag / PW'(20));
`else
    assign w_dealer_win = w_win;
`endif

    // Result 00 never matches a side, so it falls through to a loss.
    always_comb begin
        w_pay = '0;
        if (r_result != 2'b00) begin
            if (r_side == r_result) begin
                unique case (r_side)
                    2'b01:   w_pay = w_win;
                    2'b10:   w_pay = w_dealer_win;
                    2'b11:   w_pay = w_tie_win;
                    default: w_pay = '0;
                endcase
            end else if (r_result == 2'b11) begin
                w_pay = w_wag;
            end
        end
    end

    assign w_sum     = PW'(r_balance) + w_pay;
    assign w_new_bal = (w_sum > PW'(TOP)) ? {BAL_W{1'b1}} : w_sum[BAL_W-1:0];
    assign w_pay_sat = (w_pay > PW'(TOP)) ? {BAL_W{1'b1}} : w_pay[BAL_W-1:0];

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            r_state        <= S_IDLE;
            r_balance      <= BAL_W'(START_BALANCE);
            r_wager        <= '0;
            r_side         <= 2'b00;
            r_result       <= 2'b00;
            r_last_payout  <= '0;
            r_game_start   <= 1'b0;
            r_payout_valid <= 1'b0;
            r_reject       <= 1'b0;
            r_betting      <= 1'b1;
            r_bankrupt     <= 1'b0;
        end else begin
            r_game_start   <= 1'b0;
            r_payout_valid <= 1'b0;
            r_reject       <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (place_bet) begin
                        if (w_legal) begin
                            r_balance    <= r_balance - amount_in;
                            r_wager      <= amount_in;
                            r_side       <= bet_in;
                            r_game_start <= 1'b1;
                            r_betting    <= 1'b0;
                            r_state      <= S_RUN;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (game_done) begin
                        r_result <= result;
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_balance      <= w_new_bal;
                    r_last_payout  <= w_pay_sat;
                    r_payout_valid <= 1'b1;
                    if (w_new_bal == '0) begin
                        r_bankrupt <= 1'b1;
                        r_state    <= S_BROKE;
                    end else begin
                        r_betting <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_BROKE: begin
                    r_bankrupt <= 1'b1;
                    r_betting  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign game_start   = r_game_start;
    assign betting      = r_betting;
    assign balance      = r_balance;
    assign wager        = r_wager;
    assign bet_side     = r_side;
    assign last_payout  = r_last_payout;
    assign payout_valid = r_payout_valid;
    assign reject       = r_reject;
    assign bankrupt     = r_bankrupt;

endmodule

// File: tb/tb_wager_controller.sv
// Directed plus randomized rounds for wager_controller against a bankroll model.
// Model follows WAGER_COMMISSION_EN the same way the design does.
module tb_wager_controller;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b0;
    logic [1:0] bet_in = 2'b00;
    logic [7:0] amount_in = 8'd0;
    logic       place_bet = 1'b0;
    logic       game_done = 1'b0;
    logic [1:0] result = 2'b00;
    logic       game_start;
    logic       betting;
    logic [7:0] balance;
    logic [7:0] wager;
    logic [1:0] bet_side;
    logic [7:0] last_payout;
    logic       payout_valid;
    logic       reject;
    logic       bankrupt;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;
    int bal   = 100;

    wager_controller dut (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .bet_in      (bet_in),
        .amount_in   (amount_in),
        .place_bet   (place_bet),
        .game_done   (game_done),
        .result      (result),
        .game_start  (game_start),
        .betting     (betting),
        .balance     (balance),
        .wager       (wager),
        .bet_side    (bet_side),
        .last_payout (last_payout),
        .payout_valid(payout_valid),
        .reject      (reject),
        .bankrupt    (bankrupt)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic tick();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int payout(input int side, input int w, input int res);
        if (res == 0) return 0;
        if (side == 1 && res == 1) return 2 * w;
`ifdef WAGER_COMMISSION_EN
        if (side == 2 && res == 2) return 2 * w - w / 20;
`else
        if (side == 2 && res == 2) return 2 * w;
`endif
        if (side == 3 && res == 3) return 9 * w;
        if (res == 3 && side != 0) return w;
        return 0;
    endfunction

    task automatic do_reset();
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        bal = 100;
        chk("rst_balance", balance, 100);
        chk("rst_betting", betting, 1);
        chk("rst_bankrupt", bankrupt, 0);
        chk("rst_start", game_start, 0);
        chk("rst_valid", payout_valid, 0);
        chk("rst_reject", reject, 0);
    endtask

    task automatic play(input int side, input int amt, input int res, input int dly);
        bit legal;
        int p;
        legal = side != 0 && amt != 0 && amt <= 50 && amt <= bal;
        bet_in = 2'(side);
        amount_in = 8'(amt);
        place_bet = 1'b1;
        tick();
        place_bet = 1'b0;
        if (!legal) begin
            chk("rej_pulse", reject, 1);
            chk("rej_balance", balance, bal);
            chk("rej_betting", betting, 1);
            chk("rej_start", game_start, 0);
            tick();
            chk("rej_clear", reject, 0);
            return;
        end
        bal -= amt;
        chk("acc_balance", balance, bal);
        chk("acc_start", game_start, 1);
        chk("acc_betting", betting, 0);
        chk("acc_wager", wager, amt);
        chk("acc_side", bet_side, side);
        for (int i = 0; i < dly; i++) begin
            place_bet = 1'b1;
            tick();
            chk("run_start_low", game_start, 0);
            chk("run_no_reject", reject, 0);
        end
        place_bet = 1'b0;
        game_done = 1'b1;
        result = 2'(res);
        tick();
        game_done = 1'b0;
        chk("done_balance", balance, bal);
        chk("done_valid", payout_valid, 0);
        tick();
        p = payout(side, amt, res);
        bal = (bal + p > 255) ? 255 : bal + p;
        chk("set_balance", balance, bal);
        chk("set_payout", last_payout, (p > 255) ? 255 : p);
        chk("set_valid", payout_valid, 1);
        chk("set_betting", betting, (bal != 0) ? 1 : 0);
        chk("set_bankrupt", bankrupt, (bal == 0) ? 1 : 0);
        tick();
        chk("valid_clear", payout_valid, 0);
    endtask

    initial begin
        tick();
        do_reset();
        chk("rst_wager", wager, 0);
        chk("rst_payout", last_payout, 0);

        play(1, 20, 1, 0);
        chk("pwin_bal", balance, 120);
        do_reset();
        play(3, 10, 3, 1);
        chk("tie_bal", balance, 180);
        do_reset();
        play(1, 10, 3, 2);
        chk("push_bal", balance, 100);

        play(1, 0, 1, 0);
        play(1, 60, 1, 0);
        play(0, 10, 1, 0);
        play(2, 50, 1, 0);
        play(1, 20, 2, 0);
        chk("bal30", balance, 30);
        play(1, 40, 1, 0);
        play(2, 30, 0, 0);
        chk("broke_flag", bankrupt, 1);

        place_bet = 1'b1;
        bet_in = 2'b01;
        amount_in = 8'd5;
        game_done = 1'b1;
        result = 2'b01;
        tick();
        tick();
        place_bet = 1'b0;
        game_done = 1'b0;
        chk("broke_reject", reject, 0);
        chk("broke_start", game_start, 0);
        chk("broke_valid", payout_valid, 0);
        chk("broke_bal", balance, 0);
        chk("broke_betting", betting, 0);
        do_reset();

        bet_in = 2'b01;
        amount_in = 8'd30;
        place_bet = 1'b1;
        tick();
        place_bet = 1'b0;
        chk("mid_acc", balance, 70);
        do_reset();
        game_done = 1'b1;
        result = 2'b01;
        tick();
        tick();
        game_done = 1'b0;
        chk("stray_done_valid", payout_valid, 0);
        chk("stray_done_bal", balance, 100);

        play(3, 50, 3, 0);
        chk("sat_bal", balance, 255);
        do_reset();
        play(2, 40, 2, 0);

        for (int n = 0; n < 60; n++) begin
            int s;
            int a;
            s = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70))
                                            : int'($urandom_range(1, 50));
            play(s, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if (bal == 0) do_reset();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/wager_controller.md
Name: wager_controller

Overview:
- Bankroll and round scheduler for the baccarat datapath. Holds the player balance and accepts or rejects bets while in the betting phase.
- Starts a round on the card-dealing state machine with a one-cycle start pulse, waits for its done handshake, then settles the payout from the round result.
- Sits between the switch/key inputs and the round state machine. Its outputs drive the balance display and the betting indicator.

Parameters:
- START_BALANCE, 100, balance loaded on reset.
- BAL_W, 8, width of balance, wager and payout registers.
- MAX_BET, 50, largest legal wager.
- TIE_MULT, 8, tie-bet win multiplier; payout is (TIE_MULT+1)*wager, stake included.

Ports:
- slow_clock  input  1  system clock; all logic on rising edge.
- resetb  input  1  synchronous active-low reset.
- bet_in  input  2  bet side: 00 none, 01 player, 10 dealer, 11 tie.
- amount_in  input  BAL_W  requested wager.
- place_bet  input  1  bet request, sampled on each edge while in IDLE.
- game_done  input  1  round finished, from round state machine.
- result  input  2  round outcome: 01 player wins, 10 dealer wins, 11 tie; valid when game_done=1.
- game_start  output  1  one-cycle pulse that starts a round.
- betting  output  1  high while in IDLE (bets accepted).
- balance  output  BAL_W  current balance.
- wager  output  BAL_W  stake of current/last round.
- bet_side  output  2  latched bet_in of current/last round.
- last_payout  output  BAL_W  amount credited at last settle (0 on loss).
- payout_valid  output  1  one-cycle pulse when balance is updated by settle.
- reject  output  1  one-cycle pulse on an illegal bet request.
- bankrupt  output  1  high in BROKE.

Behaviour:
- Reset (resetb=0 at an edge, synchronous): state=IDLE, balance=START_BALANCE, wager=0, bet_side=00, last_payout=0, game_start=0, payout_valid=0, reject=0, bankrupt=0, betting=1.
- Reset takes priority in every state and aborts a round mid-operation; any pending game_done is discarded.
- All outputs are registered. Pulse outputs default to 0 every cycle.
- States are IDLE, RUN, SETTLE and BROKE.
- IDLE, place_bet=0: hold.
- IDLE, place_bet=1, illegal request. Illegal means any of: bet_in=00, amount_in=0, amount_in>MAX_BET, amount_in>balance.
  - reject=1 for the next cycle.
  - No state or register change.
- IDLE, place_bet=1, legal request, at the same edge:
  - balance<=balance-amount_in.
  - wager<=amount_in, bet_side<=bet_in.
  - game_start<=1 (exactly one cycle).
  - state<=RUN, betting<=0.
- RUN: place_bet is ignored (no reject).
- RUN, game_done=1: latch result; state<=SETTLE.
  - game_done in the same cycle game_start is high is legal and honoured.
- SETTLE takes one cycle. The payout P is:
  - player bet with result 01, or dealer bet with result 10: P=2*wager.
  - tie bet with result 11: P=(TIE_MULT+1)*wager.
  - player or dealer bet with result 11: P=wager (push, refund).
  - all other combinations: P=0.
  - Illegal result 00: treated as a loss, P=0.
- SETTLE actions:
  - balance<=min(balance+P, 2^BAL_W-1). Compute at width BAL_W+5 and saturate.
  - last_payout<=min(P, 2^BAL_W-1).
  - payout_valid<=1.
  - Next state is BROKE if the new balance is 0, else IDLE (betting<=1).
- BROKE: bankrupt=1, betting=0. All inputs are ignored; only reset exits.
- game_done outside RUN is ignored.
- Latency: accept to game_start high is 1 edge. game_done to balance update is 2 edges.

Optional Feature:
- Macro: WAGER_COMMISSION_EN.
- When defined, a winning dealer bet pays P=2*wager-floor(wager/20), a 5% house commission. All other payouts are unchanged.
- When undefined, a winning dealer bet pays 2*wager and no commission logic is synthesized.

Test Plan:
- Reset with defaults: balance=100, betting=1, all pulses 0, bankrupt=0.
- Player win:
  - bet 01, amount 20, place_bet: 1 edge later balance=80, game_start=1 for one cycle.
  - game_done with result 01: 2 edges later balance=120, last_payout=40, payout_valid for one cycle, betting=1.
- Tie and push:
  - tie bet 10 with result 11: balance 100→90→180, last_payout=90.
  - player bet 10 with result 11: balance 100→90→100, last_payout=10.
- Rejects:
  - amount 0, amount 60 (>MAX_BET), bet_in=00, and amount 40 with balance 30 each give a one-cycle reject.
  - balance, wager and state are unchanged; place_bet during RUN gives no reject.
- Bankruptcy:
  - two dealer bets of 50 with result 01: balance 0, bankrupt=1, betting=0.
  - further place_bet is ignored; resetb low for one edge restores balance 100.
  - resetb low mid-RUN returns to IDLE with balance=START_BALANCE.
- Saturation and commission:
  - START_BALANCE=250, tie bet 50 wins: balance 200→255 (saturated), last_payout=255.
  - with WAGER_COMMISSION_EN defined, dealer bet 40 wins: balance 60→138, last_payout=78.
